// File: rtl/switch_conditioner.sv
// Synchronizes and debounces the three raw board inputs and derives a single-cycle game-reset pulse.
// Optional SWITCH_EDGE_PULSE_EN adds startRise/randRise rising-edge pulses on the switch levels.
module switch_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic randSwitch_raw,
  input  logic startSwitch_raw,
  input  logic resetBtn_raw,
  output logic randSwitch,
  output logic startSwitch,
  output logic fsmReset
`ifdef SWITCH_EDGE_PULSE_EN
  ,
  output logic startRise,
  output logic randRise
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel order: 0 = rand, 1 = start, 2 = reset button.
  logic [2:0] raw;
  logic [2:0] stable;

  assign raw = {resetBtn_raw, startSwitch_raw, randSwitch_raw};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [CNT_W-1:0]       cnt_reg;
      logic                   stable_reg;
      logic                   s;

      assign s = sync_reg[SYNC_STAGES-1];

      // A new level must persist for DEBOUNCE_CYCLES consecutive samples; any return restarts the count.
      always_ff @(posedge clk) begin
        if (reset) begin
          sync_reg   <= '0;
          cnt_reg    <= '0;
          stable_reg <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw[gi]};
          if (s == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            stable_reg <= s;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign stable[gi] = stable_reg;
    end
  endgenerate

  logic btn_q_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q_reg <= 1'b0;
    end else begin
      btn_q_reg <= stable[2];
    end
  end

  assign randSwitch  = stable[0];
  assign startSwitch = stable[1];
  assign fsmReset    = stable[2] & ~btn_q_reg;

`ifdef SWITCH_EDGE_PULSE_EN
  logic rand_q_reg;
  logic start_q_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rand_q_reg  <= 1'b0;
      start_q_reg <= 1'b0;
    end else begin
      rand_q_reg  <= stable[0];
      start_q_reg <= stable[1];
    end
  end

  assign randRise  = stable[0] & ~rand_q_reg;
  assign startRise = stable[1] & ~start_q_reg;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: window-based debounce model checked every cycle, directed scenarios
// with literal expectations, then randomized bouncing inputs with occasional resets.
module tb_switch_conditioner;

  localparam int N = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rand_raw = 1'b0;
  logic start_raw = 1'b0;
  logic btn_raw = 1'b0;
  logic rand_sw, start_sw, fsm_reset;
`ifdef SWITCH_EDGE_PULSE_EN
  logic start_rise, rand_rise;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  switch_conditioner #(
    .DEBOUNCE_CYCLES(N),
    .SYNC_STAGES    (S)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .randSwitch_raw (rand_raw),
    .startSwitch_raw(start_raw),
    .resetBtn_raw   (btn_raw),
    .randSwitch     (rand_sw),
    .startSwitch    (start_sw),
    .fsmReset       (fsm_reset)
`ifdef SWITCH_EDGE_PULSE_EN
    ,
    .startRise      (start_rise),
    .randRise       (rand_rise)
`endif
  );

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: raw reaches the debouncer SYNC_STAGES edges late; the level flips only when the
  // last N delayed samples all disagree with the current level.
  bit dly [3][S];
  bit win [3][N];
  bit m_stable [3];
  bit m_pulse [3];

  always @(posedge clk) begin
    bit r [3];
    bit s, prev, flip;
    r[0] = rand_raw;
    r[1] = start_raw;
    r[2] = btn_raw;
    for (int ch = 0; ch < 3; ch++) begin
      if (reset) begin
        for (int i = 0; i < S; i++) dly[ch][i] = 1'b0;
        for (int i = 0; i < N; i++) win[ch][i] = 1'b0;
        m_stable[ch] = 1'b0;
        m_pulse[ch]  = 1'b0;
      end else begin
        s    = dly[ch][S-1];
        prev = m_stable[ch];
        for (int i = N - 1; i > 0; i--) win[ch][i] = win[ch][i-1];
        win[ch][0] = s;
        flip = 1'b1;
        for (int i = 0; i < N; i++) if (win[ch][i] == m_stable[ch]) flip = 1'b0;
        if (flip) m_stable[ch] = !m_stable[ch];
        m_pulse[ch] = m_stable[ch] && !prev;
        for (int i = S - 1; i > 0; i--) dly[ch][i] = dly[ch][i-1];
        dly[ch][0] = r[ch];
      end
    end
    #1;
    check("model_randSwitch", rand_sw, m_stable[0]);
    check("model_startSwitch", start_sw, m_stable[1]);
    check("model_fsmReset", fsm_reset, m_pulse[2]);
`ifdef SWITCH_EDGE_PULSE_EN
    check("model_randRise", rand_rise, m_pulse[0]);
    check("model_startRise", start_rise, m_pulse[1]);
`endif
  end

  task automatic edge_after();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // 1: all raw high through reset, level and pulse appear 6 edges after release
    reset = 1'b1; rand_raw = 1'b1; start_raw = 1'b1; btn_raw = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rand", rand_sw, 1'b0);
    check("rst_start", start_sw, 1'b0);
    check("rst_btn", fsm_reset, 1'b0);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      edge_after();
      check("t1_rand", rand_sw, k >= 6);
      check("t1_start", start_sw, k >= 6);
      check("t1_pulse", fsm_reset, k == 6);
    end
    $display("T1 release latency done t=%0t", $time);

    // 3: holding the button gave one pulse; releasing gives none
    repeat (12) begin edge_after(); check("t3_hold", fsm_reset, 1'b0); end
    @(negedge clk); btn_raw = 1'b0;
    repeat (14) begin edge_after(); check("t3_release", fsm_reset, 1'b0); end
    $display("T3 button hold/release done t=%0t", $time);

    // 2: start bounce 1,1,1,0 then steady 1
    @(negedge clk); start_raw = 1'b0;
    repeat (12) @(negedge clk);
    check("t2_pre", start_sw, 1'b0);
    start_raw = 1'b1;
    repeat (3) @(negedge clk);
    start_raw = 1'b0;
    @(negedge clk);
    start_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      edge_after();
      check("t2_start", start_sw, k >= 6);
    end
    $display("T2 bounce rejection done t=%0t", $time);

    // 5: rand and start together, then start alone falls
    @(negedge clk); rand_raw = 1'b0; start_raw = 1'b0;
    repeat (12) @(negedge clk);
    rand_raw = 1'b1; start_raw = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      edge_after();
      check("t5_rand_up", rand_sw, k >= 6);
      check("t5_start_up", start_sw, k >= 6);
    end
    @(negedge clk); start_raw = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      edge_after();
      check("t5_start_dn", start_sw, k < 6);
      check("t5_rand_hold", rand_sw, 1'b1);
    end
    $display("T5 simultaneous channels done t=%0t", $time);

    // 4: reset after two mismatch counts discards the count
    @(negedge clk); rand_raw = 1'b0;
    repeat (12) @(negedge clk);
    rand_raw = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t4_in_reset", rand_sw, 1'b0);
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      edge_after();
      check("t4_rand", rand_sw, k >= 6);
    end
    $display("T4 reset mid-count done t=%0t", $time);

    // Randomized bouncing inputs with rare resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) rand_raw = ~rand_raw;
      if ($urandom_range(0, 9) == 0) start_raw = ~start_raw;
      if ($urandom_range(0, 7) == 0) btn_raw = ~btn_raw;
      reset = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk); reset = 1'b0;
    repeat (10) @(negedge clk);
    $display("RANDOM phase done t=%0t", $time);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
